// File: rtl/fetch_buffer_mp.sv
// rtl/fetch_buffer_mp.sv - multi-port in-order fetch/dispatch buffer
//
// Circular in-order FIFO sitting between fetch and dispatch. Takes up to
// IN_W entries per cycle and offers up to OUT_W oldest entries per cycle.
// DEPTH need not be a power of two; pointers wrap by compare/subtract.
//
// Ports:
//   clock      - sole clock, rising edge
//   reset      - asynchronous, active-low reset
//   enq_data   - IN_W packed entries, lane 0 = oldest incoming
//   enq_count  - number of valid enqueue lanes, packed from lane 0
//   enq_spots  - min(DEPTH - count, IN_W), from registered state
//   flush      - empties the buffer, discards same-cycle enq/deq
//   deq_data   - OUT_W packed entries, lane 0 = oldest stored; invalid lanes 0
//   deq_valid  - min(count, OUT_W)
//   deq_count  - entries consumed by dispatch this cycle
//   count      - current occupancy
//   full       - count == DEPTH
//   empty      - count == 0
//   err        - sticky protocol-violation flag
//
// Optional feature macro: FETCH_BUFFER_PROTOCOL_CHECK_EN
//   defined   : err latches on over-requests (cleared only by reset)
//   undefined : err tied to 0, no check logic

module fetch_buffer_mp #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int IN_W   = 4,
    parameter int OUT_W  = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [IN_W*DATA_W-1:0]        enq_data,
    input  logic [$clog2(IN_W+1)-1:0]     enq_count,
    output logic [$clog2(IN_W+1)-1:0]     enq_spots,
    input  logic                          flush,
    output logic [OUT_W*DATA_W-1:0]       deq_data,
    output logic [$clog2(OUT_W+1)-1:0]    deq_valid,
    input  logic [$clog2(OUT_W+1)-1:0]    deq_count,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          full,
    output logic                          empty,
    output logic                          err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW    = PTR_W + 1;           // pointer sum width
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SW    = CNT_W + 1;           // occupancy arithmetic width
    localparam int IC_W  = $clog2(IN_W + 1);
    localparam int OC_W  = $clog2(OUT_W + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [SW-1:0] cnt_w;
    logic [SW-1:0] spots_w;
    logic [SW-1:0] vld_w;
    logic [SW-1:0] acc_w;
    logic [SW-1:0] rem_w;
    logic [SW-1:0] cnt_next_w;

    // A sum of a pointer (< DEPTH) and an offset (<= DEPTH) is < 2*DEPTH,
    // so a single conditional subtract brings it back into range.
    function automatic logic [PTR_W-1:0] wrap(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        r = (p >= PW'(DEPTH)) ? (p - PW'(DEPTH)) : p;
        return PTR_W'(r);
    endfunction

    // Availability is derived only from registered occupancy; slots freed by
    // this cycle's dequeue are not offered until the next cycle.
    always_comb begin
        cnt_w      = SW'(count_q);
        spots_w    = SW'(DEPTH) - cnt_w;
        if (spots_w > SW'(IN_W)) begin
            spots_w = SW'(IN_W);
        end
        vld_w      = (cnt_w > SW'(OUT_W)) ? SW'(OUT_W) : cnt_w;
        acc_w      = (SW'(enq_count) > spots_w) ? spots_w : SW'(enq_count);
        rem_w      = (SW'(deq_count) > vld_w)   ? vld_w   : SW'(deq_count);
        cnt_next_w = cnt_w + acc_w - rem_w;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = wrap(PW'(head_q) + PW'(rem_w));
            tail_d  = wrap(PW'(tail_q) + PW'(acc_w));
            count_d = CNT_W'(cnt_next_w);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; contents beyond the valid window are ignored.
    always_ff @(posedge clock) begin
        if (!flush) begin
            for (int i = 0; i < IN_W; i++) begin
                if (SW'(i) < acc_w) begin
                    mem_q[wrap(PW'(tail_q) + PW'(i))] <= enq_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        deq_data = '0;
        for (int j = 0; j < OUT_W; j++) begin
            if (SW'(j) < vld_w) begin
                deq_data[j*DATA_W +: DATA_W] = mem_q[wrap(PW'(head_q) + PW'(j))];
            end
        end
    end

    assign enq_spots = IC_W'(spots_w);
    assign deq_valid = OC_W'(vld_w);
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);

`ifdef FETCH_BUFFER_PROTOCOL_CHECK_EN
    logic viol;
    logic err_q;

    assign viol = (SW'(enq_count) > spots_w) || (SW'(deq_count) > vld_w) ||
                  (SW'(enq_count) > SW'(IN_W)) || (SW'(deq_count) > SW'(OUT_W));

    // Flush intentionally does not clear the flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (reset && viol) begin
            $error("fetch_buffer_mp: protocol violation enq_count=%0d enq_spots=%0d deq_count=%0d deq_valid=%0d",
                   enq_count, enq_spots, deq_count, deq_valid);
        end
    end
`endif
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_buffer_mp.sv
// tb/tb_fetch_buffer_mp.sv - directed self-checking bench for fetch_buffer_mp
module tb_fetch_buffer_mp;

    logic         clock;
    logic         reset;

    logic [255:0] enq_data;
    logic [2:0]   enq_count;
    logic [2:0]   enq_spots;
    logic         flush;
    logic [127:0] deq_data;
    logic [1:0]   deq_valid;
    logic [1:0]   deq_count;
    logic [3:0]   count;
    logic         full;
    logic         empty;
    logic         err;

    logic [255:0] enq_data6;
    logic [2:0]   enq_count6;
    logic [2:0]   enq_spots6;
    logic         flush6;
    logic [127:0] deq_data6;
    logic [1:0]   deq_valid6;
    logic [1:0]   deq_count6;
    logic [2:0]   count6;
    logic         full6;
    logic         empty6;
    logic         err6;

    int tests;
    int fails;
    logic exp_err;

    fetch_buffer_mp u_dut (
        .clock(clock), .reset(reset),
        .enq_data(enq_data), .enq_count(enq_count), .enq_spots(enq_spots),
        .flush(flush),
        .deq_data(deq_data), .deq_valid(deq_valid), .deq_count(deq_count),
        .count(count), .full(full), .empty(empty), .err(err)
    );

    fetch_buffer_mp #(.DEPTH(6)) u_d6 (
        .clock(clock), .reset(reset),
        .enq_data(enq_data6), .enq_count(enq_count6), .enq_spots(enq_spots6),
        .flush(flush6),
        .deq_data(deq_data6), .deq_valid(deq_valid6), .deq_count(deq_count6),
        .count(count6), .full(full6), .empty(empty6), .err(err6)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] a_ent(input int k);
        return 64'hA000_0000_0000_0000 + 64'(k);
    endfunction

    function automatic logic [127:0] pair(input logic [63:0] l1, input logic [63:0] l0);
        return {l1, l0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_enq(input int n, input logic [63:0] base);
        for (int i = 0; i < 4; i++) enq_data[i*64 +: 64] = base + 64'(i);
        enq_count = 3'(n);
    endtask

    task automatic set_enq6(input int n, input logic [63:0] base);
        for (int i = 0; i < 4; i++) enq_data6[i*64 +: 64] = base + 64'(i);
        enq_count6 = 3'(n);
    endtask

    initial begin
        tests = 0;
        fails = 0;
`ifdef FETCH_BUFFER_PROTOCOL_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        reset = 1'b0;
        enq_data = '0;  enq_count = '0;  deq_count = '0;  flush = 1'b0;
        enq_data6 = '0; enq_count6 = '0; deq_count6 = '0; flush6 = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick(); tick();

        // post-reset
        chk("rst_empty", 128'(empty), 128'd1);
        chk("rst_full", 128'(full), 128'd0);
        chk("rst_count", 128'(count), 128'd0);
        chk("rst_spots", 128'(enq_spots), 128'd4);
        chk("rst_valid", 128'(deq_valid), 128'd0);
        chk("rst_data", deq_data, 128'd0);
        chk("rst_err", 128'(err), 128'd0);

        // fill
        set_enq(4, a_ent(0));
        tick();
        chk("fill1_count", 128'(count), 128'd4);
        chk("fill1_valid", 128'(deq_valid), 128'd2);
        chk("fill1_data", deq_data, pair(a_ent(1), a_ent(0)));
        chk("fill1_spots", 128'(enq_spots), 128'd4);
        set_enq(4, a_ent(4));
        tick();
        chk("fill2_count", 128'(count), 128'd8);
        chk("fill2_full", 128'(full), 128'd1);
        chk("fill2_spots", 128'(enq_spots), 128'd0);

        // over-enqueue while full is dropped
        set_enq(3, 64'hB000_0000_0000_0000);
        tick();
        set_enq(0, 64'd0);
        chk("drop_count", 128'(count), 128'd8);
        chk("drop_data", deq_data, pair(a_ent(1), a_ent(0)));
        chk("drop_err", 128'(err), 128'(exp_err));

        // simultaneous enq/deq at full: enq clamped to 0, deq of 2 taken
        set_enq(2, 64'hC000_0000_0000_0000);
        deq_count = 2'd2;
        tick();
        chk("sim_count", 128'(count), 128'd6);
        chk("sim_spots", 128'(enq_spots), 128'd2);
        chk("sim_data", deq_data, pair(a_ent(3), a_ent(2)));

        set_enq(0, 64'd0);
        tick();
        chk("drain1_count", 128'(count), 128'd4);
        chk("drain1_data", deq_data, pair(a_ent(5), a_ent(4)));
        set_enq(1, 64'hC000_0000_0000_0000);
        tick();
        set_enq(0, 64'd0);
        chk("drain2_count", 128'(count), 128'd3);
        chk("drain2_data", deq_data, pair(a_ent(7), a_ent(6)));
        tick();
        chk("drain3_count", 128'(count), 128'd1);
        chk("drain3_valid", 128'(deq_valid), 128'd1);
        chk("drain3_data", deq_data, pair(64'd0, 64'hC000_0000_0000_0000));
        tick();
        chk("drain4_empty", 128'(empty), 128'd1);
        chk("drain4_data", deq_data, 128'd0);

        // empty with simultaneous enqueue: dequeue request clamped to 0
        set_enq(2, 64'hD000_0000_0000_0000);
        chk("emptyenq_valid", 128'(deq_valid), 128'd0);
        tick();
        chk("emptyenq_count", 128'(count), 128'd2);
        chk("emptyenq_data", deq_data, pair(64'hD000_0000_0000_0001, 64'hD000_0000_0000_0000));

        // build count=5, then flush with same-cycle traffic
        deq_count = 2'd0;
        set_enq(3, 64'hD000_0000_0000_0002);
        tick();
        chk("preflush_count", 128'(count), 128'd5);
        set_enq(3, 64'hE000_0000_0000_0000);
        deq_count = 2'd2;
        flush = 1'b1;
        #1;
        chk("flushcyc_count", 128'(count), 128'd5);
        tick();
        flush = 1'b0;
        deq_count = 2'd0;
        set_enq(0, 64'd0);
        chk("flush_count", 128'(count), 128'd0);
        chk("flush_empty", 128'(empty), 128'd1);
        chk("flush_valid", 128'(deq_valid), 128'd0);
        chk("flush_data", deq_data, 128'd0);
        chk("flush_spots", 128'(enq_spots), 128'd4);
        set_enq(1, 64'hF000_0000_0000_0000);
        tick();
        chk("postflush_count", 128'(count), 128'd1);
        chk("postflush_data", deq_data, pair(64'd0, 64'hF000_0000_0000_0000));

        // async reset between edges
        set_enq(2, 64'hF000_0000_0000_0001);
        tick();
        set_enq(0, 64'd0);
        chk("prerst_count", 128'(count), 128'd3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 128'(count), 128'd0);
        chk("arst_empty", 128'(empty), 128'd1);
        chk("arst_err", 128'(err), 128'd0);
        tick();
        reset = 1'b1;
        tick();

        // DEPTH=6 wrap: deq order must stay A0,A1,... across wrap
        set_enq6(4, a_ent(0));
        tick();
        chk("w_init_count", 128'(count6), 128'd4);
        chk("w_init_spots", 128'(enq_spots6), 128'd2);
        deq_count6 = 2'd2;
        for (int c = 0; c < 3; c++) begin
            set_enq6(2, a_ent(4 + 2*c));
            #1;
            chk("w_data", deq_data6, pair(a_ent(2*c + 1), a_ent(2*c)));
            tick();
            chk("w_count", 128'(count6), 128'd4);
        end
        deq_count6 = 2'd0;
        set_enq6(0, 64'd0);
        chk("w_final_data", deq_data6, pair(a_ent(7), a_ent(6)));
        chk("w_full", 128'(full6), 128'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
